// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that fronts a 4:1 mux.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4_1_rr_arbiter_pick.sv
// Combinational rotating-priority picker: the requester just after 'last' wins,
// and 'last' itself only wins when nobody else is asking.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   pick
);

    assign any = |req;

    // Walk from the lowest priority (last+4 == last) up to last+1 so the closest wins.
    always_comb begin
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[SEL_W'(last + SEL_W'(k))]) begin
                pick = SEL_W'(last + SEL_W'(k));
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 mux, with bounded hold and a turnaround gap.
// Optional MUX_ARB_LOCK_EN adds a per-requester lock that suppresses hold expiry.
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]  lock,
`endif
    output logic [NUM_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic [SEL_W-1:0]    owner
);

    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_t        state;
    logic [CNT_W-1:0]  hold_cnt;
    logic              any;
    logic [SEL_W-1:0]  pick;
    logic              locked;
    logic              release_now;

    rr_pick4 u_pick (
        .req  (req),
        .last (owner),
        .any  (any),
        .pick (pick)
    );

`ifdef MUX_ARB_LOCK_EN
    assign locked = lock[owner];
`else
    assign locked = 1'b0;
`endif

    // A dropped request and an expiry in the same cycle are one release.
    assign release_now = !req[owner] || ((hold_cnt == HOLD_MAX) && !locked);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            owner     <= SEL_W'(NUM_REQ - 1);
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (any) begin
                        state     <= BUSY;
                        gnt       <= onehot(pick);
                        sel       <= pick;
                        owner     <= pick;
                        hold_cnt  <= CNT_W'(1);
                        out_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state     <= GAP;
                        gnt       <= '0;
                        out_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Scoreboard bench for mux_4_1_rr_arbiter: a driver pushes model predictions, a monitor pops and compares.
module tb_mux_4_1_rr_arbiter;

    localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [1:0] owner;

    typedef struct {
        int         tag;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] owner;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Reference model: who owns the mux and for how many cycles it has held it.
    int   m_owner = 3;
    int   m_sel   = 0;
    int   m_held  = 0;

    mux_4_1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rn);
        exp_t e;
        @(posedge clk);
        #2;
        req   = r;
        lock  = l;
        rst_n = rn;
        if (!rn) begin
            m_owner = 3;
            m_sel   = 0;
            m_held  = 0;
        end else if (m_held > 0) begin
            if (!r[m_owner] || (m_held >= MAX_HOLD && !(LOCK_EN && l[m_owner]))) begin
                m_held = 0;
            end else if (m_held < MAX_HOLD) begin
                m_held = m_held + 1;
            end
        end else if (r != 4'b0) begin
            for (int k = 4; k >= 1; k--) begin
                if (r[(m_owner + k) % 4]) m_sel = (m_owner + k) % 4;
            end
            m_owner = m_sel;
            m_held  = 1;
        end
        e.tag   = cyc + 1;
        e.gnt   = (m_held > 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.valid = (m_held > 0);
        e.owner = 2'(m_owner);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int c, input logic [3:0] actual, input logic [3:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%b want=%b", name, c, actual, expected);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                if (e.tag < cyc) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL stale_entry cycle=%0d got=%0d want=%0d", cyc, e.tag, cyc);
                end
                checkOutput("gnt",       cyc, gnt,                e.gnt);
                checkOutput("sel",       cyc, {2'b0, sel},        {2'b0, e.sel});
                checkOutput("out_valid", cyc, {3'b0, out_valid},  {3'b0, e.valid});
                checkOutput("owner",     cyc, {2'b0, owner},      {2'b0, e.owner});
            end
        end
    end

    initial begin : driver
        logic [3:0] r;
        logic [3:0] l;
        logic       rn;
        rst_n = 1'b0;
        req   = 4'b0;
        lock  = 4'b0;

        repeat (2) applyStimulus(4'hF, 4'h0, 1'b0);

        repeat (3) applyStimulus(4'b0100, 4'h0, 1'b1);
        repeat (3) applyStimulus(4'b0000, 4'h0, 1'b1);

        repeat (80) applyStimulus(4'hF, 4'h0, 1'b1);
        repeat (2)  applyStimulus(4'h0, 4'h0, 1'b1);

        applyStimulus(4'h0, 4'h0, 1'b0);
        repeat (2)  applyStimulus(4'b0001, 4'h0, 1'b1);
        repeat (12) applyStimulus(4'b1001, 4'h0, 1'b1);
        repeat (5)  applyStimulus(4'b0001, 4'h0, 1'b1);
        repeat (3)  applyStimulus(4'b0000, 4'h0, 1'b1);

        applyStimulus(4'h0, 4'h0, 1'b0);
        repeat (20) applyStimulus(4'b0010, 4'b0010, 1'b1);
        repeat (3)  applyStimulus(4'b0010, 4'b0000, 1'b1);
        repeat (2)  applyStimulus(4'b0000, 4'b0000, 1'b1);

        repeat (3)  applyStimulus(4'b0010, 4'h0, 1'b1);
        applyStimulus(4'b0010, 4'h0, 1'b0);
        repeat (12) applyStimulus(4'hF, 4'h0, 1'b1);
        repeat (2)  applyStimulus(4'h0, 4'h0, 1'b1);

        // Slowly-toggling random traffic so grants run long enough to hit expiry and lock.
        r = 4'h0;
        l = 4'h0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
                if ($urandom_range(0, 5) == 0) l[b] = ~l[b];
            end
            rn = ($urandom_range(0, 99) != 0);
            applyStimulus(r, l, rn);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
